// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the ALU interface in the multicycle
// datapath. Accepts a decoded instruction on a valid/ready request channel,
// drives registered operands and a 4-bit control code to the ALU for ALU_LAT
// cycles, samples result/zero and returns them on a valid/ready response
// channel.
//
// state | meaning
// IDLE  | ready for a request; alu_* hold the last issued values
// EXEC  | operands held at the ALU while the latency counter runs down
// RESP  | response presented, held until rsp_ready
module alu_op_sequencer #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [WIDTH-1:0]   data1_q, data2_q;
  logic [3:0]         ctrl_q;
  logic               rsp_valid_q, rsp_zero_q, rsp_err_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic [CNT_W-1:0]   op_count_q;

  logic               legal_d;
  logic [3:0]         ctrl_d;
  logic [CNT_W-1:0]   op_count_d;

  // Decode ALUOp/funct fields into the ALU control code and a legality flag.
  always_comb begin
    legal_d = 1'b1;
    ctrl_d  = 4'b0010;
    case (req_aluop)
      2'b00: ctrl_d = 4'b0010;
      2'b01: ctrl_d = 4'b0110;
      2'b10: begin
        case (req_funct3)
          3'b000:  ctrl_d = req_funct7b5 ? 4'b0110 : 4'b0010;
          3'b111:  ctrl_d = 4'b0000;
          3'b110:  ctrl_d = 4'b0001;
          default: legal_d = 1'b0;
        endcase
      end
      default: legal_d = 1'b0;
    endcase
  end

  // Saturating increment of the completed-operation counter.
  always_comb begin
    op_count_d = op_count_q;
    if (op_count_q != {CNT_W{1'b1}}) op_count_d = op_count_q + 1'b1;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      ctrl_q       <= 4'b0000;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (legal_d) begin
              data1_q   <= req_a;
              data2_q   <= req_b;
              ctrl_q    <= ctrl_d;
              lat_cnt_q <= LAT_W'(ALU_LAT);
              state_q   <= EXEC;
            end else begin
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b0;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        EXEC: begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
          if (lat_cnt_q == LAT_W'(1)) begin
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!rsp_err_q) op_count_q <= op_count_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign alu_data1   = data1_q;
  assign alu_data2   = data2_q;
  assign alu_control = ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance 0 uses ALU_LAT=1, instance 1 ALU_LAT=3.
// A behavioural ALU answers each instance from its registered alu_* outputs.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid[2];
  logic        req_ready[2];
  logic [1:0]  req_aluop;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic [63:0] req_a, req_b;
  logic [63:0] alu_data1[2], alu_data2[2], alu_result[2];
  logic [3:0]  alu_control[2];
  logic        alu_zero[2];
  logic        rsp_valid[2], rsp_ready[2], rsp_zero[2], rsp_err[2];
  logic [63:0] rsp_result[2];
  logic [15:0] op_count[2];

  int tests = 0;
  int fails = 0;
  int exp_cnt[2];

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_f(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return 64'd0;
    endcase
  endfunction

  assign alu_result[0] = alu_f(alu_control[0], alu_data1[0], alu_data2[0]);
  assign alu_result[1] = alu_f(alu_control[1], alu_data1[1], alu_data2[1]);
  assign alu_zero[0]   = (alu_result[0] == 64'd0);
  assign alu_zero[1]   = (alu_result[1] == 64'd0);

  alu_op_sequencer #(.WIDTH(64), .ALU_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_a(req_a), .req_b(req_b), .alu_data1(alu_data1[0]), .alu_data2(alu_data2[0]),
    .alu_control(alu_control[0]), .alu_result(alu_result[0]), .alu_zero(alu_zero[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_zero(rsp_zero[0]), .rsp_err(rsp_err[0]), .op_count(op_count[0]));

  alu_op_sequencer #(.WIDTH(64), .ALU_LAT(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_a(req_a), .req_b(req_b), .alu_data1(alu_data1[1]), .alu_data2(alu_data2[1]),
    .alu_control(alu_control[1]), .alu_result(alu_result[1]), .alu_zero(alu_zero[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_zero(rsp_zero[1]), .rsp_err(rsp_err[1]), .op_count(op_count[1]));

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
    logic [63:0] res;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at accept edge +1 with req_valid dropped.
  task automatic issue(input int d, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic [63:0] a, input logic [63:0] b);
    int g = 0;
    while (!req_ready[d] && g < 20) begin
      @(posedge clk); #1; g++;
    end
    chk("wait_req_ready", 64'(req_ready[d]), 64'd1);
    req_aluop = op; req_funct3 = f3; req_funct7b5 = f7; req_a = a; req_b = b;
    req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, output int cycles);
    cycles = 1;
    while (!rsp_valid[d] && cycles < 40) begin
      @(posedge clk); #1; cycles++;
    end
  endtask

  task automatic run_op(input int d, input vec_t v, input string nm);
    logic [3:0]  pc;
    logic [63:0] p1, p2;
    int cyc;
    pc = alu_control[d]; p1 = alu_data1[d]; p2 = alu_data2[d];
    issue(d, v.aluop, v.f3, v.f7, v.a, v.b);
    chk({nm, "_busy"}, 64'(req_ready[d]), 64'd0);
    wait_rsp(d, cyc);
    chk({nm, "_latency"}, 64'(cyc), 64'(v.lat));
    if (v.err) begin
      chk({nm, "_ctrl_kept"}, 64'(alu_control[d]), 64'(pc));
      chk({nm, "_d1_kept"}, alu_data1[d], p1);
      chk({nm, "_d2_kept"}, alu_data2[d], p2);
    end else begin
      chk({nm, "_ctrl"}, 64'(alu_control[d]), 64'(v.ctrl));
      chk({nm, "_d1"}, alu_data1[d], v.a);
    end
    chk({nm, "_result"}, rsp_result[d], v.res);
    chk({nm, "_zero"}, 64'(rsp_zero[d]), 64'(v.zero));
    chk({nm, "_err"}, 64'(rsp_err[d]), 64'(v.err));
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    if (!v.err) exp_cnt[d]++;
    chk({nm, "_valid_drop"}, 64'(rsp_valid[d]), 64'd0);
    chk({nm, "_ready_back"}, 64'(req_ready[d]), 64'd1);
    chk({nm, "_op_count"}, 64'(op_count[d]), 64'(exp_cnt[d]));
  endtask

  initial begin
    int cyc;
    vec_t v;
    vecs[0] = '{2'b10, 3'b000, 1'b0, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 1'b0, 2};
    vecs[1] = '{2'b01, 3'b000, 1'b0, 64'd9, 64'd9, 4'b0110, 64'd0, 1'b1, 1'b0, 2};
    vecs[2] = '{2'b01, 3'b101, 1'b1, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2};
    vecs[3] = '{2'b10, 3'b111, 1'b0, 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 1'b0, 1'b0, 2};
    vecs[4] = '{2'b10, 3'b110, 1'b0, 64'hF0F0, 64'hFF00, 4'b0001, 64'hFFF0, 1'b0, 1'b0, 2};
    vecs[5] = '{2'b10, 3'b000, 1'b1, 64'd10, 64'd3, 4'b0110, 64'd7, 1'b0, 1'b0, 2};
    vecs[6] = '{2'b00, 3'b010, 1'b0, 64'd3, 64'd4, 4'b0010, 64'd7, 1'b0, 1'b0, 2};
    vecs[7] = '{2'b10, 3'b001, 1'b0, 64'd11, 64'd22, 4'b0000, 64'd0, 1'b0, 1'b1, 1};
    vecs[8] = '{2'b11, 3'b000, 1'b0, 64'd33, 64'd44, 4'b0000, 64'd0, 1'b0, 1'b1, 1};
    vecs[9] = '{2'b10, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0, 2};

    req_valid[0] = 0; req_valid[1] = 0; rsp_ready[0] = 0; rsp_ready[1] = 0;
    req_aluop = 0; req_funct3 = 0; req_funct7b5 = 0; req_a = 0; req_b = 0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_alu_control", 64'(alu_control[0]), 64'd0);
    chk("rst_alu_data1", alu_data1[0], 64'd0);
    chk("rst_rsp_result", rsp_result[1], 64'd0);
    chk("rst_op_count", 64'(op_count[1]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 64'(req_ready[0]), 64'd1);

    for (int i = 0; i < 10; i++) run_op(0, vecs[i], $sformatf("vec%0d", i));

    // ALU_LAT=3, response stalled four cycles with a new request held early.
    v = '{2'b10, 3'b000, 1'b0, 64'd100, 64'd23, 4'b0010, 64'd123, 1'b0, 1'b0, 4};
    run_op(1, v, "lat3_a");
    issue(1, 2'b10, 3'b000, 1'b0, 64'd100, 64'd23);
    wait_rsp(1, cyc);
    chk("lat3_latency", 64'(cyc), 64'd4);
    req_aluop = 2'b01; req_funct3 = 3'b000; req_funct7b5 = 1'b0; req_a = 64'd50; req_b = 64'd8;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(rsp_valid[1]), 64'd1);
      chk("stall_result", rsp_result[1], 64'd123);
      chk("stall_req_ready", 64'(req_ready[1]), 64'd0);
      chk("stall_ctrl", 64'(alu_control[1]), 64'b0010);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    exp_cnt[1]++;
    chk("stall_hs_valid", 64'(rsp_valid[1]), 64'd0);
    chk("stall_hs_ready", 64'(req_ready[1]), 64'd1);
    chk("stall_hs_count", 64'(op_count[1]), 64'(exp_cnt[1]));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("early_accept_busy", 64'(req_ready[1]), 64'd0);
    chk("early_accept_ctrl", 64'(alu_control[1]), 64'b0110);
    wait_rsp(1, cyc);
    chk("early_latency", 64'(cyc), 64'd4);
    chk("early_result", rsp_result[1], 64'd42);
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    exp_cnt[1]++;
    chk("early_count", 64'(op_count[1]), 64'(exp_cnt[1]));

    // Asynchronous reset during EXEC.
    issue(0, 2'b10, 3'b000, 1'b0, 64'd1, 64'd2);
    rst_n = 1'b0;
    #1;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    chk("rst_exec_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_exec_count", 64'(op_count[0]), 64'd0);
    chk("rst_exec_ctrl", 64'(alu_control[0]), 64'd0);
    chk("rst_exec_count3", 64'(op_count[1]), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_exec_ready", 64'(req_ready[0]), 64'd1);

    // Asynchronous reset during a stalled RESP with op_count=3.
    for (int i = 0; i < 3; i++) run_op(0, vecs[i], $sformatf("pre_rst%0d", i));
    issue(0, 2'b10, 3'b110, 1'b0, 64'h1, 64'h2);
    wait_rsp(0, cyc);
    chk("resp_hold_valid", 64'(rsp_valid[0]), 64'd1);
    chk("resp_hold_count", 64'(op_count[0]), 64'd3);
    rst_n = 1'b0;
    #1;
    exp_cnt[0] = 0;
    chk("rst_resp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_resp_count", 64'(op_count[0]), 64'd0);
    chk("rst_resp_result", rsp_result[0], 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp_ready", 64'(req_ready[0]), 64'd1);
    run_op(0, vecs[3], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 64-bit ALU interface: accepts decoded instruction fields plus operands on a valid/ready request channel.
- Generates the 4-bit ALU control code and drives operands to the ALU for a fixed number of cycles.
- Samples result and zero flag, then returns them on a valid/ready response channel.
- Sits between the issue stage and the ALU in the multicycle datapath.

Parameters:
- WIDTH, 64, operand/result width.
- ALU_LAT, 1, cycles operands are held to the ALU before result sampling (≥1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  sequencer can accept a request.
- req_aluop  input  2  ALUOp: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- req_funct3  input  3  instruction funct3.
- req_funct7b5  input  1  funct7 bit 5.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- alu_data1  output  WIDTH  operand A to ALU (registered).
- alu_data2  output  WIDTH  operand B to ALU (registered).
- alu_control  output  4  ALU control code (registered).
- alu_result  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  captured result.
- rsp_zero  output  1  captured zero flag.
- rsp_err  output  1  request was an illegal encoding.
- op_count  output  CNT_W  completed legal operations, saturating.

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; alu_data1/alu_data2 = 0; alu_control = 4'b0000; rsp_valid = 0; rsp_result = 0; rsp_zero = 0; rsp_err = 0; op_count = 0. req_ready = 1 after reset deasserts.
- Decode:
  - aluop 00 → 0010 (ADD).
  - aluop 01 → 0110 (SUB).
  - aluop 10, funct3 000, f7b5=0 → 0010 (ADD).
  - aluop 10, funct3 000, f7b5=1 → 0110 (SUB).
  - aluop 10, funct3 111 → 0000 (AND).
  - aluop 10, funct3 110 → 0001 (OR).
  - Everything else is illegal.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready:
    - Legal request: register operands and code onto the alu_* outputs, load wait counter with ALU_LAT, go EXEC.
    - Illegal request: alu_* unchanged; rsp_err=1, rsp_result=0, rsp_zero=0; go RESP.
  - EXEC: req_ready=0; alu_* held stable. Counter decrements each cycle. On the ALU_LAT-th EXEC cycle, sample alu_result/alu_zero into rsp_result/rsp_zero, set rsp_err=0, go RESP.
  - RESP: req_ready=0, rsp_valid=1. All rsp_* held stable until rsp_ready=1. On handshake, go IDLE; op_count increments if rsp_err=0, saturating at all-ones.
- Latency:
  - Legal: rsp_valid is first high ALU_LAT+1 cycles after the accepting edge.
  - Illegal: rsp_valid is high 1 cycle after the accepting edge.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after the response handshake.
- alu_* outputs keep the last issued values while in IDLE and RESP (no glitching to 0).
- Arithmetic is performed entirely by the ALU; the sequencer does no width extension and passes WIDTH bits through unchanged (wrap-around is preserved).
- req_valid while req_ready=0 is ignored; the requester must hold it.
- rst_n asserted in any state, including mid-EXEC or RESP with rsp_ready low:
  - Immediate return to reset values.
  - The pending response is discarded and op_count is cleared.

Test Plan:
- aluop=10, f3=000, f7b5=0, A=5, B=7, ALU_LAT=1 → alu_control=0010; rsp_result=12, rsp_zero=0, rsp_err=0; rsp_valid exactly 2 cycles after accept; op_count=1 after handshake.
- aluop=01, A=9, B=9 → control 0110, rsp_result=0, rsp_zero=1. Then A=0, B=1 → rsp_result=64'hFFFF_FFFF_FFFF_FFFF, zero=0.
- aluop=10: f3=111 with A=0xF0F0, B=0xFF00 → 0xF000; f3=110 with same operands → 0xFFF0. Control codes 0000 and 0001 respectively.
- aluop=10, f3=001 and aluop=11 → rsp_err=1, result=0, alu_* unchanged; rsp_valid 1 cycle after accept; op_count not incremented.
- ALU_LAT=3, rsp_ready held low 4 cycles after rsp_valid → rsp_valid 4 cycles after accept; rsp_* stable throughout; req_ready=0 until the cycle after the handshake; a req_valid presented early is not accepted.
- rst_n pulsed low during EXEC, then during RESP with op_count=3 → rsp_valid=0 and op_count=0 immediately (asynchronous); req_ready=1 after release; the next request completes normally.
